// File: rtl/hamming_pkg.sv
// ============================================================================
// hamming_pkg : shared types and defaults for the Hamming scrub controller
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hamming_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    CAPTURE = 2'd1,
    CHECK   = 2'd2,
    FIX     = 2'd3
  } hsc_state_e;

  localparam int HSC_SCRUB_INTERVAL = 16;
  localparam int HSC_CHECK_CYCLES   = 2;
  localparam int HSC_FIX_CYCLES     = 2;
  localparam int HSC_ERR_CNT_W      = 8;

  // Phase timer width; CHECK/FIX lengths must fit below 2**HSC_PHASE_W.
  localparam int HSC_PHASE_W = 8;
  typedef logic [HSC_PHASE_W-1:0] hsc_phase_t;

endpackage

`default_nettype wire

// File: rtl/hsc_phase_timer.sv
// ============================================================================
// hsc_phase_timer : loadable down-counter, done while the count is zero
// Revision        : 1.0
// ============================================================================
`default_nettype none

module hsc_phase_timer
  import hamming_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [HSC_PHASE_W-1:0] load_val,
  output logic                   done
);

  hsc_phase_t r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/hamming_scrub_ctrl.sv
// ============================================================================
// hamming_scrub_ctrl : gates the Hamming counter enable, inserting periodic
//                      and requested scrub windows (CAPTURE/CHECK/FIX).
// Options            : HSC_ERR_STATS_EN enables the saturating error counter.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module hamming_scrub_ctrl
  import hamming_pkg::*;
#(
  parameter int SCRUB_INTERVAL = HSC_SCRUB_INTERVAL,
  parameter int CHECK_CYCLES   = HSC_CHECK_CYCLES,
  parameter int FIX_CYCLES     = HSC_FIX_CYCLES,
  parameter int ERR_CNT_W      = HSC_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cnt_req_i,
  output logic                 cnt_ack_o,
  input  logic                 scrub_req_i,
  output logic                 enable_o,
  input  logic                 dp_busy_i,
  input  logic                 dp_err_i,
  output logic                 scrub_busy_o,
  output logic                 err_pulse_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int         CNT_W        = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [CNT_W-1:0] C_INTERVAL = CNT_W'(SCRUB_INTERVAL);
  localparam hsc_phase_t C_CHECK_LOAD = hsc_phase_t'(CHECK_CYCLES - 1);
  localparam hsc_phase_t C_FIX_LOAD   = hsc_phase_t'(FIX_CYCLES - 1);

  localparam logic [1:0] ST_RUN     = RUN;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;
  localparam logic [1:0] ST_CHECK   = CHECK;
  localparam logic [1:0] ST_FIX     = FIX;

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_int_cnt, w_int_cnt_nxt;
  logic             r_pend, w_pend_nxt;
  logic             r_err, w_err_nxt;
  logic             r_enable, r_ack, r_busy, r_pulse;
  logic             w_due, w_grant, w_fix_entry;
  logic             w_timer_load, w_timer_done;
  hsc_phase_t       w_timer_val;

  hsc_phase_timer u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_timer_load),
    .load_val (w_timer_val),
    .done     (w_timer_done)
  );

  // Grants are issued on the edge that lands in RUN, so the registered
  // enable is only ever high while the state register reads RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_int_cnt_nxt = r_int_cnt;
    w_pend_nxt    = r_pend;
    w_err_nxt     = r_err;
    w_grant       = 1'b0;
    w_fix_entry   = 1'b0;
    w_timer_load  = 1'b0;
    w_timer_val   = C_CHECK_LOAD;
    w_due         = (r_int_cnt == C_INTERVAL) || r_pend;
    case (r_state)
      ST_RUN: begin
        if (w_due) begin
          w_state_nxt = ST_CAPTURE;
          w_pend_nxt  = 1'b0;
        end else begin
          w_grant = cnt_req_i;
          if (scrub_req_i) w_pend_nxt = 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_state_nxt   = ST_CHECK;
        w_int_cnt_nxt = '0;
        w_timer_load  = 1'b1;
        w_timer_val   = C_CHECK_LOAD;
      end
      ST_CHECK: begin
        w_err_nxt = r_err | (dp_err_i & dp_busy_i);
        if (w_timer_done) begin
          if (w_err_nxt) begin
            w_state_nxt  = ST_FIX;
            w_fix_entry  = 1'b1;
            w_timer_load = 1'b1;
            w_timer_val  = C_FIX_LOAD;
          end else begin
            w_state_nxt = ST_RUN;
            w_grant     = cnt_req_i;
          end
        end
      end
      ST_FIX: begin
        if (w_timer_done) begin
          w_state_nxt = ST_RUN;
          w_err_nxt   = 1'b0;
          w_grant     = cnt_req_i;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    if (w_grant) w_int_cnt_nxt = w_int_cnt_nxt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_int_cnt <= '0;
      r_pend    <= 1'b0;
      r_err     <= 1'b0;
      r_enable  <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_int_cnt <= w_int_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_err     <= w_err_nxt;
      r_enable  <= w_grant;
      r_ack     <= w_grant;
      r_busy    <= (w_state_nxt != ST_RUN);
      r_pulse   <= w_fix_entry;
    end
  end

  assign enable_o     = r_enable;
  assign cnt_ack_o    = r_ack;
  assign scrub_busy_o = r_busy;
  assign err_pulse_o  = r_pulse;

`ifdef HSC_ERR_STATS_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_fix_entry && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hamming_scrub_ctrl.sv
// ============================================================================
// tb_hamming_scrub_ctrl : directed scenarios plus random traffic against a
//                         cycle-level behavioural model of the scrub sequence.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_hamming_scrub_ctrl;

  localparam int SI = 4;
  localparam int CC = 2;
  localparam int FC = 2;
  localparam int EW = 2;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_req = 1'b0;
  logic          scrub_req = 1'b0;
  logic          dp_busy = 1'b0;
  logic          dp_err = 1'b0;
  logic          cnt_ack, enable, scrub_busy, err_pulse;
  logic [EW-1:0] err_cnt;

  always #5 clk = ~clk;

  hamming_scrub_ctrl #(
    .SCRUB_INTERVAL (SI),
    .CHECK_CYCLES   (CC),
    .FIX_CYCLES     (FC),
    .ERR_CNT_W      (EW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt_req_i    (cnt_req),
    .cnt_ack_o    (cnt_ack),
    .scrub_req_i  (scrub_req),
    .enable_o     (enable),
    .dp_busy_i    (dp_busy),
    .dp_err_i     (dp_err),
    .scrub_busy_o (scrub_busy),
    .err_pulse_o  (err_pulse),
    .err_cnt_o    (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 = counting, 1 = parity capture, 2 = syndrome check, 3 = fix.
  int m_phase, m_left, m_since_scrub, e_errcnt;
  bit m_pend, m_err, e_grant, e_busy, e_pulse;

  function automatic void model_reset();
    m_phase = 0; m_left = 0; m_since_scrub = 0; e_errcnt = 0;
    m_pend = 0; m_err = 0; e_grant = 0; e_busy = 0; e_pulse = 0;
  endfunction

  function automatic void model_step();
    bit grant = 0;
    e_pulse = 0;
    case (m_phase)
      0: begin
        if (m_since_scrub >= SI || m_pend) begin
          m_phase = 1;
          m_pend  = 0;
        end else begin
          grant = cnt_req;
          if (scrub_req) m_pend = 1;
        end
      end
      1: begin
        m_since_scrub = 0;
        m_phase = 2;
        m_left  = CC;
      end
      2: begin
        if (dp_err && dp_busy) m_err = 1;
        m_left--;
        if (m_left == 0) begin
          if (m_err) begin
            m_phase = 3;
            m_left  = FC;
            e_pulse = 1;
`ifdef HSC_ERR_STATS_EN
            if (e_errcnt < ERR_MAX) e_errcnt++;
`endif
          end else begin
            m_phase = 0;
            grant   = cnt_req;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 0;
          m_err   = 0;
          grant   = cnt_req;
        end
      end
    endcase
    if (grant) m_since_scrub++;
    e_grant = grant;
    e_busy  = (m_phase != 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("enable", enable, e_grant);
    check("ack", cnt_ack, e_grant);
    check("scrub_busy", scrub_busy, e_busy);
    check("err_pulse", err_pulse, e_pulse);
    check("err_cnt", err_cnt, e_errcnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enable"}, enable, 0);
    check({tag, "_ack"}, cnt_ack, 0);
    check({tag, "_busy"}, scrub_busy, 0);
    check({tag, "_pulse"}, err_pulse, 0);
    check({tag, "_errcnt"}, err_cnt, 0);
  endtask

  task automatic wait_check_phase();
    for (int i = 0; i < 10 && m_phase != 2; i++) tick();
    if (m_phase != 2) check("wait_check_timeout", m_phase, 2);
  endtask

  // Held request: count acks before the first window and the window length.
  task automatic run_burst(input string tag);
    int hi = 0;
    int lo = 0;
    bit seen_lo = 0;
    bit done = 0;
    cnt_req = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (enable && !seen_lo) hi++;
      else if (!enable && !done) begin seen_lo = 1; lo++; end
      else if (enable && seen_lo) done = 1;
    end
    check({tag, "_acks"}, hi, SI);
    check({tag, "_low_len"}, lo, 1 + CC);
    cnt_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse, fixlen, nbusy;
    bit infix;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;

    // Periodic scrub with a continuously requesting master
    run_burst("t1");
    repeat (4) tick();

    // Single error in CHECK: one pulse, FIX window, counter bump
    scrub_req = 1; tick(); scrub_req = 0;
    wait_check_phase();
    dp_err = 1; dp_busy = 1; tick(); dp_err = 0; dp_busy = 0;
    npulse = 0; fixlen = 0; infix = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (err_pulse) begin npulse++; infix = 1; end
      if (infix && scrub_busy) fixlen++;
    end
    check("t2_pulses", npulse, 1);
    check("t2_fix_len", fixlen, FC);
`ifdef HSC_ERR_STATS_EN
    check("t2_err_cnt", err_cnt, 1);
`else
    check("t2_err_cnt", err_cnt, 0);
`endif

    // Manual scrub pulse with no counting traffic
    scrub_req = 1; tick(); scrub_req = 0;
    check("t3_not_yet_busy", scrub_busy, 0);
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin tick(); nbusy += int'(scrub_busy); end
    check("t3_window_len", nbusy, 1 + CC);

    // Request held across the whole window coalesces into one scrub
    scrub_req = 1; tick(); tick();
    check("t4_in_window", scrub_busy, 1);
    for (int i = 0; i < 10 && scrub_busy; i++) tick();
    scrub_req = 0;
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin tick(); nbusy += int'(scrub_busy); end
    check("t4_no_second_window", nbusy, 0);

    // Asynchronous reset in the middle of CHECK
    scrub_req = 1; tick(); scrub_req = 0;
    wait_check_phase();
    rst_n = 0;
    #1;
    check_all_zero("t5_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    run_burst("t5");

    // Repeated forced errors drive the statistics counter into saturation
    for (int k = 0; k < 5; k++) begin
      scrub_req = 1; tick(); scrub_req = 0;
      dp_err = 1; dp_busy = 1;
      repeat (3 + CC + FC) tick();
      dp_err = 0; dp_busy = 0;
      tick();
    end
`ifdef HSC_ERR_STATS_EN
    check("t6_err_cnt_sat", err_cnt, ERR_MAX);
`else
    check("t6_err_cnt_sat", err_cnt, 0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cnt_req   = ($urandom_range(9, 0) < 7);
      scrub_req = ($urandom_range(19, 0) == 0);
      dp_busy   = $urandom_range(1, 0) == 1;
      dp_err    = ($urandom_range(4, 0) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
